// File: rtl/rom_image_loader.sv
// rom_image_loader: sweeps the boot ROM, packs bytes into words, writes memory.
// Optional byte checksum enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_image_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned MAX_BYTES    = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic        mem_write_valid,
  input  logic        mem_write_ready,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset,
  output logic        load_complete,
  output logic        load_error,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [31:0] LP_GUARD = 32'(MAX_BYTES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_rom_address;
  logic [31:0] r_buf;
  logic        r_last;
  logic        r_err;

  logic [1:0]  w_lane;
  logic        w_guard;
  logic        w_close;
  logic        w_begin;
  logic [31:0] w_buf_fill;

  assign w_lane  = r_rom_address[1:0];
  assign w_guard = (r_rom_address == LP_GUARD);
  assign w_close = (w_lane == 2'd3) || rom_done || w_guard;
  assign w_begin = start &&
                   ((r_state == S_IDLE) || (r_state == S_DONE));

  // Merge the current ROM byte into its lane of the word buffer.
  always_comb begin
    w_buf_fill = r_buf;
    w_buf_fill[8*w_lane +: 8] = rom_byte;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next    = r_state;
    mem_write_valid = 1'b0;
    cpu_reset       = 1'b1;
    load_complete   = 1'b0;
    load_error      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_close) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_write_valid = 1'b1;
        if (mem_write_ready) begin
          w_state_next = r_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        cpu_reset     = 1'b0;
        load_complete = 1'b1;
        load_error    = r_err;
        if (start) begin
          w_state_next = S_FETCH;
          cpu_reset    = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Address sweep, word packing and end-of-image bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rom_address <= '0;
      r_buf         <= '0;
      r_last        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_rom_address <= '0;
            r_buf         <= '0;
            r_last        <= 1'b0;
            r_err         <= 1'b0;
          end
        end
        S_FETCH: begin
          r_buf <= w_buf_fill;
          if (w_close) begin
            r_last <= rom_done || w_guard;
            r_err  <= w_guard && !rom_done;
          end else begin
            r_rom_address <= r_rom_address + 32'd1;
          end
        end
        S_WRITE: begin
          if (mem_write_ready && !r_last) begin
            r_rom_address <= r_rom_address + 32'd1;
            r_buf         <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_address       = r_rom_address;
  assign mem_write_address = BASE_ADDRESS +
                             {r_rom_address[31:2], 2'b00};
  assign mem_write_data    = r_buf;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running modulo-2^32 sum of every byte taken from the ROM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_begin) begin
      r_checksum <= '0;
    end else if (r_state == S_FETCH) begin
      r_checksum <= r_checksum + {24'd0, rom_byte};
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_begin;

  assign w_unused_begin = w_begin;
  assign checksum       = 32'd0;
`endif

endmodule
